// File: rtl/gmem_pkg.sv
// gmem_pkg: shared state encoding and lane constants for the global-memory burst engine
// Exports: state_t (FSM states), LANES (words per quad), DIR_WR/DIR_RD (command direction)
package gmem_pkg;
    localparam int LANES = 4;
    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_LOAD  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;
endpackage

// File: rtl/gmem_quad_buffer.sv
// gmem_quad_buffer: four-lane word buffer with serial fill/unload and parallel quad load
// Ports: clock, resetn (async active-low); wr_en/wr_data store into lane[idx] and advance;
//        adv advances idx only; load captures rd1..rd4 and rewinds idx;
//        lane1..lane4 expose the lanes, sel_data is lane[idx], idx is the lane index.
module gmem_quad_buffer
    import gmem_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          adv,
    input  logic          load,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] rd3,
    input  logic [DW-1:0] rd4,
    output logic [DW-1:0] lane1,
    output logic [DW-1:0] lane2,
    output logic [DW-1:0] lane3,
    output logic [DW-1:0] lane4,
    output logic [DW-1:0] sel_data,
    output logic [1:0]    idx
);
    logic [DW-1:0] lanes [LANES];
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lanes <= '{default: '0};
            idx   <= '0;
        end else if (load) begin
            lanes <= '{rd1, rd2, rd3, rd4};
            idx   <= '0;
        end else if (wr_en) begin
            lanes[idx] <= wr_data;
            idx        <= idx + 2'd1;
        end else if (adv) begin
            idx <= idx + 2'd1;
        end
    end
    assign lane1    = lanes[0];
    assign lane2    = lanes[1];
    assign lane3    = lanes[2];
    assign lane4    = lanes[3];
    assign sel_data = lanes[idx];
endmodule

// File: rtl/gmem_burst_ctrl.sv
// gmem_burst_ctrl: burst engine moving 16-bit stream words to/from quad-wide global memory
// Ports: clock, resetn (async active-low); cmd_* command handshake (dir/addr/quads);
//        in_* write-stream sink; out_* read-stream source; mem_addr/mem_we/mem_wd1..4
//        drive the memory, mem_rd1..4 are its combinational read lanes; busy, done status.
module gmem_burst_ctrl
    import gmem_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int CNTW = 3
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_dir,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [CNTW-1:0] cmd_quads,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wd1,
    output logic [DW-1:0]   mem_wd2,
    output logic [DW-1:0]   mem_wd3,
    output logic [DW-1:0]   mem_wd4,
    input  logic [DW-1:0]   mem_rd1,
    input  logic [DW-1:0]   mem_rd2,
    input  logic [DW-1:0]   mem_rd3,
    input  logic [DW-1:0]   mem_rd4,
    output logic            busy,
    output logic            done
);
    state_t          state;
    logic [AW-1:0]   cur;
    logic [CNTW-1:0] rem;
    logic [1:0]      idx;
    logic            wr_en, adv, last;
    assign wr_en = state == S_FILL && in_valid;
    assign adv   = state == S_DRAIN && out_ready;
    assign last  = idx == 2'(LANES - 1);
    gmem_quad_buffer #(.DW(DW)) u_buf (
        .clock    (clock),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (in_data),
        .adv      (adv),
        .load     (state == S_LOAD),
        .rd1      (mem_rd1),
        .rd2      (mem_rd2),
        .rd3      (mem_rd3),
        .rd4      (mem_rd4),
        .lane1    (mem_wd1),
        .lane2    (mem_wd2),
        .lane3    (mem_wd3),
        .lane4    (mem_wd4),
        .sel_data (out_data),
        .idx      (idx)
    );
    // Handshake/status outputs are pure decodes of the state register.
    assign cmd_ready = state == S_IDLE;
    assign in_ready  = state == S_FILL;
    assign out_valid = state == S_DRAIN;
    assign mem_we    = state == S_WRITE;
    assign done      = state == S_DONE;
    assign busy      = state inside {S_FILL, S_WRITE, S_LOAD, S_DRAIN};
    assign mem_addr  = cur;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cur   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    cur   <= cmd_addr;
                    rem   <= cmd_quads;
                    state <= cmd_quads == '0 ? S_DONE : cmd_dir == DIR_RD ? S_LOAD : S_FILL;
                end
                S_FILL: if (in_valid && last) state <= S_WRITE;
                S_WRITE: begin
                    cur   <= cur + AW'(LANES);
                    rem   <= rem - CNTW'(1);
                    state <= rem == CNTW'(1) ? S_DONE : S_FILL;
                end
                S_LOAD: state <= S_DRAIN;
                S_DRAIN: if (out_ready && last) begin
                    cur   <= cur + AW'(LANES);
                    rem   <= rem - CNTW'(1);
                    state <= rem == CNTW'(1) ? S_DONE : S_LOAD;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmem_burst_ctrl.sv
// tb_gmem_burst_ctrl: scoreboard bench for gmem_burst_ctrl with a 16-word memory model
module tb_gmem_burst_ctrl;
    logic        clock = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [3:0]  cmd_addr;
    logic [2:0]  cmd_quads;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wd1, mem_wd2, mem_wd3, mem_wd4;
    logic [15:0] mem_rd1, mem_rd2, mem_rd3, mem_rd4;
    logic        busy, done;

    gmem_burst_ctrl dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_quads(cmd_quads),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3), .mem_wd4(mem_wd4),
        .mem_rd1(mem_rd1), .mem_rd2(mem_rd2), .mem_rd3(mem_rd3), .mem_rd4(mem_rd4),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Memory model: combinational read lanes, quad write on the rising edge.
    logic [15:0] mem [16];
    assign mem_rd1 = mem[mem_addr];
    assign mem_rd2 = mem[4'(mem_addr + 4'd1)];
    assign mem_rd3 = mem[4'(mem_addr + 4'd2)];
    assign mem_rd4 = mem[4'(mem_addr + 4'd3)];
    always @(posedge clock) if (mem_we) begin
        mem[mem_addr]              <= mem_wd1;
        mem[4'(mem_addr + 4'd1)]   <= mem_wd2;
        mem[4'(mem_addr + 4'd2)]   <= mem_wd3;
        mem[4'(mem_addr + 4'd3)]   <= mem_wd4;
    end

    typedef struct { logic [3:0] a; logic [63:0] d; } wr_t;
    wr_t         wq[$];
    logic [15:0] oq[$];
    logic [3:0]  aq[$];
    int checks = 0, errors = 0;
    int we_cnt = 0, rd_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = '0;

    // Monitor: samples on the falling edge, pops scoreboard entries on every DUT event.
    always @(negedge clock) begin
        if (!resetn) stall_prev = 1'b0;
        else begin
            if (mem_we) begin
                wr_t w;
                we_cnt++;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0h wd=%h", mem_addr, {mem_wd1, mem_wd2, mem_wd3, mem_wd4});
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || {mem_wd1, mem_wd2, mem_wd3, mem_wd4} !== w.d) begin
                        errors++;
                        $display("FAIL write: got addr=%0h wd=%h, expected addr=%0h wd=%h",
                                 mem_addr, {mem_wd1, mem_wd2, mem_wd3, mem_wd4}, w.a, w.d);
                    end
                end
            end
            if (out_valid && out_ready) begin
                rd_cnt++;
                checks++;
                if (oq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: data=%h", out_data);
                end else begin
                    logic [15:0] e;
                    e = oq.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_word: got %h expected %h", out_data, e);
                    end
                end
            end
            // LOAD is the only busy state with no handshake and no write strobe.
            if (busy && !in_ready && !out_valid && !mem_we) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: addr=%0h", mem_addr);
                end else begin
                    logic [3:0] ea;
                    ea = aq.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL load_addr: got %0h expected %0h", mem_addr, ea);
                    end
                end
            end
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, stall_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic d, input logic [3:0] a, input logic [2:0] q);
        int n;
        for (n = 0; n < 50 && !cmd_ready; n++) cyc();
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_dir = d; cmd_addr = a; cmd_quads = q; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic put_word(input logic [15:0] w);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        chk("in_accept_wait", acc, 1);
    endtask

    task automatic wait_done(input string n);
        logic found, prev_busy;
        found = 1'b0;
        prev_busy = busy;
        for (int k = 0; k < 100 && !found; k++) begin
            prev_busy = busy;
            cyc();
            found = done;
        end
        chk(n, found, 1);
        chk({n, "_busy"}, {prev_busy, busy}, 2'b10);
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_ctrl"}, {cmd_ready, in_ready, out_valid, mem_we, busy, done}, 6'b100000);
        chk({n, "_data"}, {mem_addr, mem_wd1, mem_wd2, mem_wd3, mem_wd4, out_data}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
        resetn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_quads = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) cyc();
        chk_reset("reset");
        resetn = 1'b1;
        cyc();

        // 1: single quad write at 4, done the cycle after the write strobe
        wq.push_back('{4'd4, 64'h1111_2222_3333_4444});
        send_cmd(1'b0, 4'd4, 3'd1);
        put_word(16'h1111); put_word(16'h2222); put_word(16'h3333); put_word(16'h4444);
        chk("t1_we", {mem_we, done}, 2'b10);
        cyc();
        chk("t1_done", {mem_we, done, busy}, 3'b010);
        cyc();
        chk("t1_idle", {cmd_ready, done}, 2'b10);

        // 2: two-quad read from 12, second quad wraps to 0
        out_ready = 1'b1;
        aq.push_back(4'd12); aq.push_back(4'd0);
        for (int i = 12; i < 16; i++) oq.push_back(16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) oq.push_back(16'hA000 + 16'(i));
        send_cmd(1'b1, 4'd12, 3'd2);
        chk("t2_load_first", {busy, out_valid, mem_addr}, {1'b1, 1'b0, 4'd12});
        cyc();
        chk("t2_first_valid", {out_valid, out_data}, {1'b1, 16'hA00C});
        wait_done("t2_done");
        chk("t2_drained", oq.size(), 0);

        // 3: read with out_ready toggling 1,0,1,0
        w0 = rd_cnt;
        aq.push_back(4'd8);
        for (int i = 8; i < 12; i++) oq.push_back(16'hA000 + 16'(i));
        send_cmd(1'b1, 4'd8, 3'd1);
        for (int n = 0; n < 60 && !done; n++) begin
            out_ready = (n % 2) == 0;
            cyc();
        end
        chk("t3_done", done, 1);
        chk("t3_words", rd_cnt - w0, 4);
        out_ready = 1'b1;
        cyc();

        // 4: zero-quad command completes through DONE without touching memory
        w0 = we_cnt;
        send_cmd(1'b0, 4'd2, 3'd0);
        chk("t4_done_pulse", {done, busy, mem_we}, 3'b100);
        cyc();
        chk("t4_done_end", {done, cmd_ready}, 2'b01);
        chk("t4_no_we", we_cnt - w0, 0);

        // 5: reset after two accepted words drops the partial quad
        w0 = we_cnt;
        send_cmd(1'b0, 4'd8, 3'd1);
        put_word(16'hDEAD); put_word(16'hBEEF);
        resetn = 1'b0;
        #1;
        chk_reset("t5_reset");
        cyc(); cyc();
        chk("t5_no_we", we_cnt - w0, 0);
        resetn = 1'b1;
        cyc();
        wq.push_back('{4'd8, 64'h5555_6666_7777_8888});
        send_cmd(1'b0, 4'd8, 3'd1);
        put_word(16'h5555); put_word(16'h6666); put_word(16'h7777); put_word(16'h8888);
        wait_done("t5_done");
        chk("t5_mem", {mem[8], mem[9], mem[10], mem[11]}, 64'h5555_6666_7777_8888);

        // 6: two-quad write with a bubble after every word
        wq.push_back('{4'd0, 64'hB001_B002_B003_B004});
        wq.push_back('{4'd4, 64'hB005_B006_B007_B008});
        send_cmd(1'b0, 4'd0, 3'd2);
        for (int i = 1; i <= 8; i++) begin
            put_word(16'hB000 + 16'(i));
            if (i != 8) cyc();
        end
        wait_done("t6_done");
        chk("t6_mem", {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]},
            128'hB001_B002_B003_B004_B005_B006_B007_B008);

        repeat (3) cyc();
        chk("final_writes", {we_cnt[7:0], 8'(wq.size())}, {8'd4, 8'd0});
        chk("final_reads", {rd_cnt[7:0], 8'(oq.size()), 8'(aq.size())}, {8'd12, 8'd0, 8'd0});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
